// File: rtl/music_pkg.sv
// Shared score-entry layout and sequencer state encoding.
// Pure definitions; no timing, no flow control.
package music_pkg;

  localparam int NOTE_W  = 6;
  localparam int DUR_W   = 3;
  localparam int SCORE_W = NOTE_W + DUR_W;

  localparam logic [NOTE_W-1:0] NOTE_REST = '0;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    PLAY
  } state_t;

  // Duration field holds crotchets-1 so a 3-bit field spans 1..8 crotchets
  typedef struct packed {
    logic [DUR_W-1:0]  dur;
    logic [NOTE_W-1:0] note;
  } score_t;

endpackage

// File: rtl/music_sequencer_beat_timer.sv
// Crotchet tick counter plus phrase counter; strobes are combinational from registered counts.
// No backpressure: counts every cycle enable is high, clear has priority.
module beat_timer #(
  parameter int TICKS  = 6_250_000,
  parameter int PHRASE = 16,
  parameter int GAP    = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic crotchet,
  output logic phrase,
  output logic last_tick,
  output logic in_gap
);

  localparam int TW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam int PW = (PHRASE > 1) ? $clog2(PHRASE) : 1;

  logic [TW-1:0] tick;
  logic [TW-1:0] tick_nxt;
  logic [PW-1:0] phr;

  assign last_tick = (tick == TW'(TICKS - 1));
  assign crotchet  = enable && last_tick;
  assign phrase    = crotchet && (phr == PW'(PHRASE - 1));

  always_comb begin
    tick_nxt = tick;
    if (clear) begin
      tick_nxt = '0;
    end else if (enable) begin
      tick_nxt = last_tick ? '0 : tick + TW'(1);
    end
  end

  // Looks one cycle ahead so the caller can register gate off it
  generate
    if (GAP > 0) begin : g_gap
      assign in_gap = (tick_nxt >= TW'(TICKS - GAP));
    end else begin : g_no_gap
      assign in_gap = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick <= '0;
      phr  <= '0;
    end else begin
      tick <= tick_nxt;
      if (clear) begin
        phr <= '0;
      end else if (crotchet) begin
        phr <= phrase ? '0 : phr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/music_sequencer.sv
// Score playback controller: walks a synchronous score ROM, drives note/gate and timing strobes.
// Note/gate/note_start are registered (first note 2 cycles after run rises); no backpressure.
module music_sequencer
  import music_pkg::*;
#(
  parameter int TICKS_PER_CROTCHET   = 6_250_000,
  parameter int CROTCHETS_PER_PHRASE = 16,
  parameter int SCORE_LEN            = 64,
  parameter int GAP_TICKS            = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         run,
  output logic [$clog2(SCORE_LEN)-1:0] score_addr,
  input  logic [SCORE_W-1:0]           score_data,
  output logic [NOTE_W-1:0]            note,
  output logic                         gate,
  output logic                         note_start,
  output logic                         crotchet,
  output logic                         phrase,
  output logic                         playing
);

  localparam int AW = $clog2(SCORE_LEN);

  state_t             state;
  state_t             state_nxt;
  score_t             entry;
  logic [AW-1:0]      addr_inc;
  logic [AW-1:0]      addr_nxt;
  logic [NOTE_W-1:0]  note_nxt;
  logic [DUR_W-1:0]   rem;
  logic [DUR_W-1:0]   rem_nxt;
  logic               start_nxt;
  logic               gate_nxt;
  logic               last_tick;
  logic               in_gap;

  assign entry    = score_t'(score_data);
  assign addr_inc = (score_addr == AW'(SCORE_LEN - 1)) ? '0 : score_addr + AW'(1);
  assign playing  = (state == PLAY);

  beat_timer #(
    .TICKS  (TICKS_PER_CROTCHET),
    .PHRASE (CROTCHETS_PER_PHRASE),
    .GAP    (GAP_TICKS)
  ) u_beat_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (state != PLAY),
    .enable    (state == PLAY),
    .crotchet  (crotchet),
    .phrase    (phrase),
    .last_tick (last_tick),
    .in_gap    (in_gap)
  );

  always_comb begin
    state_nxt = state;
    addr_nxt  = score_addr;
    note_nxt  = note;
    rem_nxt   = rem;
    start_nxt = 1'b0;
    case (state)
      IDLE: begin
        addr_nxt = '0;
        note_nxt = NOTE_REST;
        rem_nxt  = '0;
        if (run) state_nxt = PRIME;
      end
      PRIME, PLAY: begin
        if (!run) begin
          state_nxt = IDLE;
          addr_nxt  = '0;
          note_nxt  = NOTE_REST;
          rem_nxt   = '0;
        end else if (state == PRIME || (last_tick && rem == '0)) begin
          // ROM already holds the entry at score_addr, so the next note loads with no dead cycle
          state_nxt = PLAY;
          note_nxt  = entry.note;
          rem_nxt   = entry.dur;
          start_nxt = 1'b1;
          addr_nxt  = addr_inc;
        end else if (last_tick) begin
          rem_nxt = rem - DUR_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    gate_nxt = (state_nxt == PLAY) && (note_nxt != NOTE_REST) && !((rem_nxt == '0) && in_gap);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      score_addr <= '0;
      note       <= NOTE_REST;
      rem        <= '0;
      note_start <= 1'b0;
      gate       <= 1'b0;
    end else begin
      state      <= state_nxt;
      score_addr <= addr_nxt;
      note       <= note_nxt;
      rem        <= rem_nxt;
      note_start <= start_nxt;
      gate       <= gate_nxt;
    end
  end

endmodule

// File: doc/music_sequencer.md
Name: music_sequencer

Overview:
- Score-playback controller that sequences the PWM tone generator and supplies the crotchet/phrase timing strobes consumed by the display.
- Steps through an external synchronous score ROM; each entry is a note code plus a duration in crotchets.
- Presents the current note and a gate to the tone datapath.
- Sits between the top level, the score ROM and the tone/PWM generator; is the single source of musical timing.

Parameters:
- TICKS_PER_CROTCHET, 6_250_000: clk cycles per crotchet; must be >= 2.
- CROTCHETS_PER_PHRASE, 16: crotchets per phrase; must be >= 1.
- SCORE_LEN, 64: number of score entries; addresses wrap from SCORE_LEN-1 to 0.
- GAP_TICKS, 0: articulation gap, in ticks; gate is low for the last GAP_TICKS cycles of each note; must be < TICKS_PER_CROTCHET.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- run  in  1  level; high = play, low = stop and return to idle
- score_addr  out  $clog2(SCORE_LEN)  score ROM address
- score_data  in  9  ROM data, valid 1 cycle after score_addr changes; [8:6] = duration-1 (1..8 crotchets), [5:0] = note code (0 = rest)
- note  out  6  current note code to the tone generator
- gate  out  1  high = tone generator sounds note
- note_start  out  1  1-cycle pulse on the cycle a new note is latched
- crotchet  out  1  1-cycle pulse at the end of every crotchet
- phrase  out  1  1-cycle pulse coincident with every CROTCHETS_PER_PHRASE-th crotchet pulse
- playing  out  1  high while in PLAY

Behaviour:
- Reset values: all outputs 0; score_addr = 0; state IDLE; all counters 0.
- IDLE:
  - score_addr = 0, gate = 0.
  - When run = 1: go to PRIME.
- PRIME (1 cycle): waits for the ROM data of address 0.
  - Next cycle: latch note and duration from score_data, pulse note_start, set score_addr = 1 (wrap rule applies), go to PLAY.
  - Clear the tick counter, crotchet-remaining counter and phrase counter.
- PLAY:
  - Tick counter runs 0..TICKS_PER_CROTCHET-1.
  - On terminal tick: pulse crotchet and decrement remaining crotchets.
  - The phrase counter increments on each crotchet; phrase pulses when it wraps from CROTCHETS_PER_PHRASE-1 to 0.
- Note end (terminal tick while remaining = 0), on the same edge:
  - Latch score_data as the next note (ROM already prefetched; no dead cycle).
  - Pulse note_start.
  - Advance score_addr by one, modulo SCORE_LEN.
  - Note boundaries are therefore exactly (dur+1)*TICKS_PER_CROTCHET cycles apart.
- gate:
  - gate = 1 in PLAY when note != 0 and the cycle is not within the last GAP_TICKS ticks of the note's final crotchet.
  - Rests keep gate low but still generate crotchet and phrase strobes.
  - Registered: asserts on the same cycle note_start is asserted.
- run = 0 in PRIME or PLAY:
  - Next cycle go to IDLE.
  - gate, note, playing and the strobes drop to 0; score_addr = 0.
  - A crotchet that completes on the same cycle run falls is still pulsed; no pulse afterwards.
  - Restart always begins at entry 0 with the phrase count cleared.
- rst mid-play: immediate asynchronous return to reset values.
- Single-crotchet notes (dur field 0) back-to-back: note_start every TICKS_PER_CROTCHET cycles.
- Wrap: after entry SCORE_LEN-1 the next note is entry 0, seamlessly; the phrase counter is not reset by the wrap.
- Counters: tick counter is $clog2(TICKS_PER_CROTCHET) bits; remaining counter is 3 bits; phrase counter is $clog2(CROTCHETS_PER_PHRASE) bits (minimum 1).

Decomposition:
- music_pkg holds:
  - Score field widths and positions: NOTE_W = 6, DUR_W = 3.
  - NOTE_REST = 0.
  - State enum: IDLE, PRIME, PLAY.
- Sub-module beat_timer (tick counter plus phrase counter):
  - Inputs: clear, enable.
  - Outputs: crotchet, phrase, last_tick, in_gap.
  - music_sequencer holds the FSM, score addressing, note latch and gate logic.

Test Plan:
- Common settings: TICKS = 4, PHRASE = 4, SCORE_LEN = 4, GAP = 1, ROM = {(C=5, d0), (rest, d1), (9, d0), (12, d2)}.
- Reset held then released, run = 0 for 20 cycles -> all outputs 0, score_addr = 0 throughout.
- run rises at cycle T:
  - note_start and note = 5 at T+2, gate = 1 at T+2..T+4, gate = 0 at T+5.
  - crotchet at T+5; note = 0 at T+6 with gate low for 8 cycles; note = 9 at T+14.
- Phrase timing: crotchet pulses every 4 cycles; phrase coincides with the 4th, 8th and 12th crotchet pulses; entry 0 replays 7 crotchets after the first start (wrap check, score_addr sequence 1, 2, 3, 0).
- Drop run mid-note 3, then raise it 10 cycles later -> outputs 0 the cycle after the drop; replay starts at entry 0 with phrase alignment reset.
- Assert rst asynchronously mid-crotchet -> outputs 0 immediately (no clock edge required); resumes correctly after release with run high.
- GAP_TICKS = 0 with all single-crotchet non-rest notes -> gate stays continuously high; note_start every 4 cycles.
